// File: rtl/coin_start_seq.sv
// Turns a player start press into a frame-timed coin pulse, settle gap and start pulse.
// The manual coin key is ORed onto the coin output.
module coin_start_seq #(
  parameter int unsigned COIN_FRAMES  = 4,
  parameter int unsigned GAP_FRAMES   = 8,
  parameter int unsigned START_FRAMES = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic frame_tick,
  input  logic start1_req,
  input  logic start2_req,
  input  logic coin_req,
  output logic coin_out,
  output logic start1_out,
  output logic start2_out,
  output logic busy
);

  localparam logic [7:0] CoinLim  = 8'(COIN_FRAMES);
  localparam logic [7:0] GapLim   = 8'(GAP_FRAMES);
  localparam logic [7:0] StartLim = 8'(START_FRAMES);

  typedef enum logic [1:0] {StIdle, StCoin, StGap, StStart} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       sel_q, sel_d;  // 0: player 1, 1: player 2
  logic       start1_q, start2_q, coin_req_q;
  logic       rise1, rise2;

  assign rise1   = start1_req & ~start1_q;
  assign rise2   = start2_req & ~start2_q;
  assign cnt_inc = cnt_q + 8'd1;

  // Edge registers reset to 1 so a key held through reset is not seen as a press.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      sel_q      <= 1'b0;
      start1_q   <= 1'b1;
      start2_q   <= 1'b1;
      coin_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      start1_q   <= start1_req;
      start2_q   <= start2_req;
      coin_req_q <= coin_req;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (rise1) begin
          state_d = StCoin;
          sel_d   = 1'b0;
          cnt_d   = 8'd0;
        end else if (rise2) begin
          state_d = StCoin;
          sel_d   = 1'b1;
          cnt_d   = 8'd0;
        end
      end
      StCoin: begin
        if (frame_tick) begin
          if (cnt_inc == CoinLim) begin
            state_d = StGap;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StGap: begin
        if (frame_tick) begin
          if (cnt_inc == GapLim) begin
            state_d = StStart;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StStart: begin
        if (frame_tick) begin
          if (cnt_inc == StartLim) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    coin_out   = (state_q == StCoin) | coin_req_q;
    start1_out = (state_q == StStart) & ~sel_q;
    start2_out = (state_q == StStart) & sel_q;
    busy       = (state_q != StIdle);
  end

endmodule

// File: tb/tb_coin_start_seq.sv
// Bench for coin_start_seq: three instances (default, all-ones, long coin) share stimulus;
// expected outputs are queued when driven and checked one edge later.
module tb_coin_start_seq;

  localparam int unsigned Cf0 = 4,   Gf0 = 8, Sf0 = 4;
  localparam int unsigned Cf1 = 1,   Gf1 = 1, Sf1 = 1;
  localparam int unsigned Cf2 = 255, Gf2 = 8, Sf2 = 4;

  localparam logic [3:0] ExIdle = 4'b0000;
  localparam logic [3:0] ExCoin = 4'b1001;
  localparam logic [3:0] ExGap  = 4'b0001;
  localparam logic [3:0] ExSt1  = 4'b0101;
  localparam logic [3:0] ExSt2  = 4'b0011;

  logic clk = 1'b0;
  logic rst, tick, s1, s2, coin;
  logic [3:0] outs [3];

  always #5 clk = ~clk;

  coin_start_seq #(.COIN_FRAMES(Cf0), .GAP_FRAMES(Gf0), .START_FRAMES(Sf0)) u_dut0 (
    .clk_sys(clk), .reset(rst), .frame_tick(tick), .start1_req(s1), .start2_req(s2),
    .coin_req(coin), .coin_out(outs[0][3]), .start1_out(outs[0][2]),
    .start2_out(outs[0][1]), .busy(outs[0][0])
  );
  coin_start_seq #(.COIN_FRAMES(Cf1), .GAP_FRAMES(Gf1), .START_FRAMES(Sf1)) u_dut1 (
    .clk_sys(clk), .reset(rst), .frame_tick(tick), .start1_req(s1), .start2_req(s2),
    .coin_req(coin), .coin_out(outs[1][3]), .start1_out(outs[1][2]),
    .start2_out(outs[1][1]), .busy(outs[1][0])
  );
  coin_start_seq #(.COIN_FRAMES(Cf2), .GAP_FRAMES(Gf2), .START_FRAMES(Sf2)) u_dut2 (
    .clk_sys(clk), .reset(rst), .frame_tick(tick), .start1_req(s1), .start2_req(s2),
    .coin_req(coin), .coin_out(outs[2][3]), .start1_out(outs[2][2]),
    .start2_out(outs[2][1]), .busy(outs[2][0])
  );

  // Zero frame counts are illegal.
  initial begin
    assert (Cf0 >= 1 && Gf0 >= 1 && Sf0 >= 1 && Cf1 >= 1 && Gf1 >= 1 && Sf1 >= 1 &&
            Cf2 >= 1 && Gf2 >= 1 && Sf2 >= 1 && Cf2 <= 255)
    else begin
      $display("FAIL param_range: a frame-count parameter is outside 1..255");
      $fatal(1);
    end
  end

  typedef struct packed {
    logic r, t, a, b, c;
    logic [3:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0] exp;
    int         dut;
    string      tag;
    int         step;
  } sb_t;

  sb_t   sb [$];
  sb_t   cur;
  int    n_vec = 0;
  int    n_err = 0;
  int    step  = 0;
  int    chk_dut = 0;
  string tag = "init";
  logic  lvl_s1 = 1'b0, lvl_s2 = 1'b0, lvl_coin = 1'b0;
  vec_t  vt [9];

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      n_vec++;
      if (outs[cur.dut] !== cur.exp) begin
        n_err++;
        $display("FAIL %s step %0d dut%0d: {coin,s1,s2,busy} got %b want %b",
                 cur.tag, cur.step, cur.dut, outs[cur.dut], cur.exp);
      end
    end
  end

  task automatic apply(input logic r, input logic t, input logic a, input logic b,
                       input logic c, input logic [3:0] exp);
    sb_t e;
    rst  = r;
    tick = t;
    s1   = a;
    s2   = b;
    coin = c;
    e.exp  = exp;
    e.dut  = chk_dut;
    e.tag  = tag;
    e.step = step;
    sb.push_back(e);
    step++;
    @(negedge clk);
  endtask

  // n frame ticks spaced sp cycles apart; the last tick shows the following phase.
  task automatic tick_phase(input int n, input logic [3:0] during, input logic [3:0] after,
                            input int sp);
    for (int k = 1; k <= n; k++) begin
      for (int j = 1; j < sp; j++) apply(1'b0, 1'b0, lvl_s1, lvl_s2, lvl_coin, during);
      apply(1'b0, 1'b1, lvl_s1, lvl_s2, lvl_coin, (k == n) ? after : during);
    end
  endtask

  task automatic run_seq(input int cf, input int gf, input int sf, input int sp,
                         input logic [3:0] st);
    tick_phase(cf, ExCoin, ExGap, sp);
    tick_phase(gf, ExGap, st, sp);
    tick_phase(sf, st, ExIdle, sp);
  endtask

  task automatic press_p1();
    lvl_s1 = 1'b0;
    apply(1'b0, 1'b0, 1'b0, lvl_s2, lvl_coin, ExIdle);
    lvl_s1 = 1'b1;
    apply(1'b0, 1'b0, 1'b1, lvl_s2, lvl_coin, ExCoin);
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ExIdle};
    vt[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ExIdle};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ExIdle};
    vt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ExIdle};
    vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1000};
    vt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1000};
    vt[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1000};
    vt[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ExIdle};
    vt[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ExIdle};

    rst = 1'b1; tick = 1'b0; s1 = 1'b1; s2 = 1'b0; coin = 1'b0;
    @(negedge clk);

    // Key held through reset, then 50 frames: no sequence.
    tag = "held_reset";
    for (int i = 0; i < 4; i++) apply(vt[i].r, vt[i].t, vt[i].a, vt[i].b, vt[i].c, vt[i].exp);
    tag = "held_50";
    for (int f = 0; f < 50; f++) begin
      apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ExIdle);
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ExIdle);
    end
    tag = "coin_idle";
    for (int i = 4; i < 9; i++) apply(vt[i].r, vt[i].t, vt[i].a, vt[i].b, vt[i].c, vt[i].exp);

    // Single P1 start, press coincident with a tick, ticks every 100 cycles.
    tag = "p1_single";
    lvl_s1 = 1'b1;
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ExCoin);
    run_seq(4, 8, 4, 100, ExSt1);

    // Both keys rise together: P1 wins, P2 edge lost.
    tag = "simul";
    lvl_s1 = 1'b0; lvl_s2 = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ExIdle);
    lvl_s1 = 1'b1; lvl_s2 = 1'b1;
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ExCoin);
    run_seq(4, 8, 4, 3, ExSt1);
    for (int i = 0; i < 10; i++) apply(1'b0, i[0], 1'b1, 1'b1, 1'b0, ExIdle);

    // P2 rising during GAP is dropped.
    tag = "p2_in_gap";
    lvl_s2 = 1'b0;
    press_p1();
    tick_phase(4, ExCoin, ExGap, 3);
    tick_phase(3, ExGap, ExGap, 3);
    lvl_s2 = 1'b1;
    tick_phase(5, ExGap, ExSt1, 3);
    tick_phase(4, ExSt1, ExIdle, 3);
    for (int i = 0; i < 20; i++) apply(1'b0, i[0], 1'b1, 1'b1, 1'b0, ExIdle);

    // Reset in GAP at count 3 aborts; next press runs the full gap again.
    tag = "reset_gap";
    lvl_s2 = 1'b0;
    press_p1();
    tick_phase(4, ExCoin, ExGap, 2);
    tick_phase(3, ExGap, ExGap, 2);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ExIdle);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ExIdle);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ExIdle);
    press_p1();
    run_seq(4, 8, 4, 2, ExSt1);

    // Manual coin during START ORs onto the outputs without disturbing timing.
    tag = "coin_start";
    press_p1();
    tick_phase(4, ExCoin, ExGap, 2);
    tick_phase(8, ExGap, ExSt1, 2);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1101);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1101);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1101);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ExSt1);
    tick_phase(3, ExSt1, ExIdle, 2);

    // P2 path on the default instance.
    tag = "p2_single";
    lvl_s1 = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ExIdle);
    lvl_s2 = 1'b1;
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ExCoin);
    run_seq(4, 8, 4, 2, ExSt2);

    // All counts 1, tick on the cycle right after entry.
    tag = "ones";
    chk_dut = 1;
    lvl_s2 = 1'b0;
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ExIdle);
    press_p1();
    run_seq(1, 1, 1, 1, ExSt1);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ExIdle);

    // Coin phase of 255 frames, no counter wrap.
    tag = "coin255";
    chk_dut = 2;
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ExIdle);
    press_p1();
    run_seq(255, 8, 4, 2, ExSt1);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ExIdle);

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
